// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/acknowledge memory bus between mem_access_unit and memory
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wmask;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wmask, bus_wdata,
    input  bus_ack, bus_err, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wmask, bus_wdata,
    output bus_ack, bus_err, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - FETCH/MEMORY stage responder: bus access, alignment check, load extension
module mem_access_unit #(
  parameter int NUM_STAGES   = 7,
  parameter int FETCH_STAGE  = 1,
  parameter int MEMORY_STAGE = 5
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [NUM_STAGES-1:0] stage_active_i,
  output logic [NUM_STAGES-1:0] stage_done_o,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           addr_i,
  input  logic                  is_load_i,
  input  logic                  is_store_i,
  input  logic [1:0]            size_i,
  input  logic                  load_unsigned_i,
  input  logic [31:0]           store_data_i,
  output logic [31:0]           instr_o,
  output logic [31:0]           load_data_o,
  output logic                  mem_addr_fault_o,
  output logic                  mem_access_fault_o,
  output logic                  mem_fault_is_store_o,
  mem_access_unit_if.master     bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  localparam logic [NUM_STAGES-1:0] FETCH_BIT = NUM_STAGES'(1) << FETCH_STAGE;
  localparam logic [NUM_STAGES-1:0] MEM_BIT   = NUM_STAGES'(1) << MEMORY_STAGE;

  state_e                state_q;
  logic                  cur_q;
  logic                  abort_q;
  logic                  store_q;
  logic                  uns_q;
  logic [1:0]            size_q;
  logic [1:0]            off_q;
  logic [NUM_STAGES-1:0] done_q;
  logic [31:0]           instr_q;
  logic [31:0]           load_q;
  logic                  addr_fault_q;
  logic                  access_fault_q;
  logic                  fault_store_q;
  logic                  req_q;
  logic                  we_q;
  logic [31:0]           baddr_q;
  logic [3:0]            wmask_q;
  logic [31:0]           wdata_q;

  logic        cur_active_d;
  logic        misaligned_d;
  logic [3:0]  lane_mask_d;
  logic [31:0] lane_wdata_d;
  logic [31:0] shifted_d;
  logic [31:0] load_ext_d;
  logic        unused_stage;

  assign unused_stage = ^stage_active_i;
  assign cur_active_d = cur_q ? stage_active_i[MEMORY_STAGE] : stage_active_i[FETCH_STAGE];
  assign misaligned_d = ((size_i == 2'b01) && addr_i[0]) ||
                        (size_i[1] && (addr_i[1:0] != 2'b00));

  always_comb begin
    lane_mask_d  = 4'b1111;
    lane_wdata_d = 32'h0;
    if (is_store_i) begin
      case (size_i)
        2'b00: begin
          lane_mask_d  = 4'b0001 << addr_i[1:0];
          lane_wdata_d = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          lane_mask_d  = 4'b0011 << addr_i[1:0];
          lane_wdata_d = {2{store_data_i[15:0]}};
        end
        default: lane_wdata_d = store_data_i;
      endcase
    end
  end

  // Offset and size are latched at request time so the datapath may move on during REQ.
  always_comb begin
    shifted_d = bus.bus_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_ext_d = {{24{~uns_q & shifted_d[7]}}, shifted_d[7:0]};
      2'b01:   load_ext_d = {{16{~uns_q & shifted_d[15]}}, shifted_d[15:0]};
      default: load_ext_d = shifted_d;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= S_IDLE;
      cur_q          <= 1'b0;
      abort_q        <= 1'b0;
      store_q        <= 1'b0;
      uns_q          <= 1'b0;
      size_q         <= 2'b00;
      off_q          <= 2'b00;
      done_q         <= '0;
      instr_q        <= 32'h0;
      load_q         <= 32'h0;
      addr_fault_q   <= 1'b0;
      access_fault_q <= 1'b0;
      fault_store_q  <= 1'b0;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      baddr_q        <= 32'h0;
      wmask_q        <= 4'h0;
      wdata_q        <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (stage_active_i[FETCH_STAGE]) begin
            cur_q   <= 1'b0;
            store_q <= 1'b0;
            if (pc_i[1:0] != 2'b00) begin
              state_q       <= S_DONE;
              done_q        <= FETCH_BIT;
              addr_fault_q  <= 1'b1;
              fault_store_q <= 1'b0;
            end else begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              baddr_q <= {pc_i[31:2], 2'b00};
              wmask_q <= 4'b1111;
              wdata_q <= 32'h0;
            end
          end else if (stage_active_i[MEMORY_STAGE]) begin
            cur_q   <= 1'b1;
            store_q <= is_store_i;
            size_q  <= size_i;
            off_q   <= addr_i[1:0];
            uns_q   <= load_unsigned_i;
            if (!is_load_i && !is_store_i) begin
              state_q <= S_DONE;
              done_q  <= MEM_BIT;
            end else if (misaligned_d) begin
              state_q       <= S_DONE;
              done_q        <= MEM_BIT;
              addr_fault_q  <= 1'b1;
              fault_store_q <= is_store_i;
            end else begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
              we_q    <= is_store_i;
              baddr_q <= {addr_i[31:2], 2'b00};
              wmask_q <= lane_mask_d;
              wdata_q <= lane_wdata_d;
            end
          end
        end
        S_REQ: begin
          if (!cur_active_d) abort_q <= 1'b1;
          if (bus.bus_err || bus.bus_ack) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            // An abandoned stage still lets the transfer finish, but its outcome is dropped.
            if (abort_q || !cur_active_d) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DONE;
              done_q  <= cur_q ? MEM_BIT : FETCH_BIT;
              if (bus.bus_err) begin
                access_fault_q <= 1'b1;
                fault_store_q  <= store_q;
              end else if (!cur_q) begin
                instr_q <= bus.bus_rdata;
              end else if (!store_q) begin
                load_q <= load_ext_d;
              end
            end
          end
        end
        S_DONE: begin
          if (!cur_active_d) begin
            state_q        <= S_IDLE;
            done_q         <= '0;
            addr_fault_q   <= 1'b0;
            access_fault_q <= 1'b0;
            fault_store_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stage_done_o         = done_q;
  assign instr_o              = instr_q;
  assign load_data_o          = load_q;
  assign mem_addr_fault_o     = addr_fault_q;
  assign mem_access_fault_o   = access_fault_q;
  assign mem_fault_is_store_o = fault_store_q;
  assign bus.bus_req          = req_q;
  assign bus.bus_we           = we_q;
  assign bus.bus_addr         = baddr_q;
  assign bus.bus_wmask        = wmask_q;
  assign bus.bus_wdata        = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  stage_active;
  logic [6:0]  stage_done;
  logic [31:0] pc, addr, store_data, instr, load_data;
  logic        is_load, is_store, load_unsigned;
  logic [1:0]  size;
  logic        mem_addr_fault, mem_access_fault, mem_fault_is_store;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  mem_access_unit_if bus ();

  mem_access_unit #(.NUM_STAGES(7), .FETCH_STAGE(1), .MEMORY_STAGE(5)) dut (
    .clk_i                (clk),
    .reset_ni             (reset_n),
    .stage_active_i       (stage_active),
    .stage_done_o         (stage_done),
    .pc_i                 (pc),
    .addr_i               (addr),
    .is_load_i            (is_load),
    .is_store_i           (is_store),
    .size_i               (size),
    .load_unsigned_i      (load_unsigned),
    .store_data_i         (store_data),
    .instr_o              (instr),
    .load_data_o          (load_data),
    .mem_addr_fault_o     (mem_addr_fault),
    .mem_access_fault_o   (mem_access_fault),
    .mem_fault_is_store_o (mem_fault_is_store),
    .bus                  (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h, expected <scoreboard empty>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic respond(input int wait_cycles, input logic a, input logic e, input logic [31:0] rd);
    repeat (wait_cycles) @(negedge clk);
    bus.bus_ack   = a;
    bus.bus_err   = e;
    bus.bus_rdata = rd;
    @(negedge clk);
    bus.bus_ack = 1'b0;
    bus.bus_err = 1'b0;
  endtask

  task automatic mem_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] sd);
    is_load = ld; is_store = st; size = sz; load_unsigned = uns; addr = a; store_data = sd;
    stage_active = 7'h20;
  endtask

  task automatic release_stage(input string tag);
    push(32'h0); push(32'h0); push(32'h0);
    stage_active = 7'h00;
    @(negedge clk);
    chk({tag, "_done_clr"}, 32'(stage_done));
    chk({tag, "_afault_clr"}, 32'(mem_addr_fault));
    chk({tag, "_xfault_clr"}, 32'(mem_access_fault));
  endtask

  initial begin
    reset_n = 1'b0; stage_active = 7'h00; pc = 32'h0;
    is_load = 1'b0; is_store = 1'b0; size = 2'b00; load_unsigned = 1'b0;
    addr = 32'h0; store_data = 32'h0;
    bus.bus_ack = 1'b0; bus.bus_err = 1'b0; bus.bus_rdata = 32'h0;
    repeat (2) @(negedge clk);

    // reset state
    push(0); push(0); push(0); push(0); push(0); push(0);
    chk("rst_done", 32'(stage_done));
    chk("rst_req", 32'(bus.bus_req));
    chk("rst_instr", instr);
    chk("rst_load", load_data);
    chk("rst_afault", 32'(mem_addr_fault));
    chk("rst_xfault", 32'(mem_access_fault));
    reset_n = 1'b1;
    @(negedge clk);

    // aligned fetch, ack sampled two edges after bus_req rises
    push(1); push(32'h100); push(0); push(32'hF); push(0);
    push(32'h2); push(32'h1234_5678); push(0); push(0); push(0); push(32'h2);
    pc = 32'h100; stage_active = 7'h02;
    @(negedge clk);
    chk("f_req", 32'(bus.bus_req));
    chk("f_addr", bus.bus_addr);
    chk("f_we", 32'(bus.bus_we));
    chk("f_mask", 32'(bus.bus_wmask));
    chk("f_done_early", 32'(stage_done));
    respond(1, 1'b1, 1'b0, 32'h1234_5678);
    chk("f_done", 32'(stage_done));
    chk("f_instr", instr);
    chk("f_req_fall", 32'(bus.bus_req));
    chk("f_afault", 32'(mem_addr_fault));
    chk("f_xfault", 32'(mem_access_fault));
    @(negedge clk);
    chk("f_hold", 32'(stage_done));
    release_stage("f");

    // misaligned fetch
    push(0); push(32'h2); push(1); push(0);
    pc = 32'h102; stage_active = 7'h02;
    @(negedge clk);
    chk("fm_req", 32'(bus.bus_req));
    chk("fm_done", 32'(stage_done));
    chk("fm_afault", 32'(mem_addr_fault));
    chk("fm_fstore", 32'(mem_fault_is_store));
    release_stage("fm");

    // signed byte load from top lane
    push(1); push(32'h200); push(0); push(32'h20); push(32'hFFFF_FF80);
    mem_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h203, 32'h0);
    @(negedge clk);
    chk("lb_req", 32'(bus.bus_req));
    chk("lb_addr", bus.bus_addr);
    chk("lb_we", 32'(bus.bus_we));
    respond(0, 1'b1, 1'b0, 32'h80FF_FF12);
    chk("lb_done", 32'(stage_done));
    chk("lb_data", load_data);
    release_stage("lb");

    // unsigned byte load, same access
    push(32'h20); push(32'h0000_0080);
    mem_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h203, 32'h0);
    @(negedge clk);
    respond(0, 1'b1, 1'b0, 32'h80FF_FF12);
    chk("lbu_done", 32'(stage_done));
    chk("lbu_data", load_data);
    release_stage("lbu");

    // half store upper lanes
    push(1); push(32'h300); push(32'hC); push(32'hABCD_ABCD);
    push(32'h20); push(32'h0000_0080); push(0);
    mem_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h302, 32'h0000_ABCD);
    @(negedge clk);
    chk("sh_we", 32'(bus.bus_we));
    chk("sh_addr", bus.bus_addr);
    chk("sh_mask", 32'(bus.bus_wmask));
    chk("sh_wdata", bus.bus_wdata);
    respond(2, 1'b1, 1'b0, 32'hFFFF_FFFF);
    chk("sh_done", 32'(stage_done));
    chk("sh_load_kept", load_data);
    chk("sh_xfault", 32'(mem_access_fault));
    release_stage("sh");

    // byte store lane 1
    push(32'h2); push(32'h5A5A_5A5A); push(32'h20);
    mem_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h1234_565A);
    @(negedge clk);
    chk("sb_mask", 32'(bus.bus_wmask));
    chk("sb_wdata", bus.bus_wdata);
    respond(0, 1'b1, 1'b0, 32'h0);
    chk("sb_done", 32'(stage_done));
    release_stage("sb");

    // misaligned half store
    push(0); push(32'h20); push(1); push(1);
    mem_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h303, 32'h0000_ABCD);
    @(negedge clk);
    chk("shm_req", 32'(bus.bus_req));
    chk("shm_done", 32'(stage_done));
    chk("shm_afault", 32'(mem_addr_fault));
    chk("shm_fstore", 32'(mem_fault_is_store));
    release_stage("shm");

    // word load with err and ack together
    push(32'h20); push(1); push(0); push(0); push(32'h0000_0080);
    mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    @(negedge clk);
    respond(1, 1'b1, 1'b1, 32'h1111_1111);
    chk("lwe_done", 32'(stage_done));
    chk("lwe_xfault", 32'(mem_access_fault));
    chk("lwe_fstore", 32'(mem_fault_is_store));
    chk("lwe_afault", 32'(mem_addr_fault));
    chk("lwe_load_kept", load_data);
    release_stage("lwe");

    // signed half load from upper half
    push(32'hFFFF_8001);
    mem_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h402, 32'h0);
    @(negedge clk);
    respond(0, 1'b1, 1'b0, 32'h8001_0000);
    chk("lh_data", load_data);
    release_stage("lh");

    // load and store both set behaves as store
    push(1); push(32'hF); push(1); push(1);
    mem_op(1'b1, 1'b1, 2'b10, 1'b0, 32'h500, 32'h0BAD_F00D);
    @(negedge clk);
    chk("ls_we", 32'(bus.bus_we));
    chk("ls_mask", 32'(bus.bus_wmask));
    respond(0, 1'b0, 1'b1, 32'h0);
    chk("ls_xfault", 32'(mem_access_fault));
    chk("ls_fstore", 32'(mem_fault_is_store));
    release_stage("ls");

    // misaligned word load
    push(1); push(0);
    mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h502, 32'h0);
    @(negedge clk);
    chk("lwm_afault", 32'(mem_addr_fault));
    chk("lwm_fstore", 32'(mem_fault_is_store));
    release_stage("lwm");

    // stage dropped during REQ: transfer completes, result discarded
    push(1); push(0); push(32'h1234_5678); push(0); push(0);
    pc = 32'h200; stage_active = 7'h02;
    @(negedge clk);
    chk("ab_req", 32'(bus.bus_req));
    stage_active = 7'h00;
    respond(1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("ab_done", 32'(stage_done));
    chk("ab_instr_kept", instr);
    chk("ab_req_fall", 32'(bus.bus_req));
    @(negedge clk);
    chk("ab_done_later", 32'(stage_done));

    // fetch after abort, minimum latency
    push(32'h2); push(32'hCAFE_0001);
    pc = 32'h104; stage_active = 7'h02;
    @(negedge clk);
    respond(0, 1'b1, 1'b0, 32'hCAFE_0001);
    chk("f2_done", 32'(stage_done));
    chk("f2_instr", instr);
    release_stage("f2");

    // asynchronous reset while in REQ
    push(1); push(0); push(0); push(0); push(0);
    pc = 32'h108; stage_active = 7'h02;
    @(negedge clk);
    chk("rr_req_before", 32'(bus.bus_req));
    #2 reset_n = 1'b0;
    #1;
    chk("rr_req", 32'(bus.bus_req));
    chk("rr_done", 32'(stage_done));
    chk("rr_instr", instr);
    chk("rr_load", load_data);
    stage_active = 7'h00;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // no-op MEMORY stage after reset
    push(32'h20); push(0); push(0); push(0);
    mem_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("nop_done", 32'(stage_done));
    chk("nop_req", 32'(bus.bus_req));
    chk("nop_afault", 32'(mem_addr_fault));
    chk("nop_xfault", 32'(mem_access_fault));
    release_stage("nop");

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d leftover entries, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
